// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundle of every handshake/bus signal on both sides of the memory port
//   arbiter: NUM_REQ requester channels (LSU side) plus the single shared
//   memory port.
//
//   Requester side (per channel, packed [NUM_REQ-1:0]):
//     req_read_valid / req_read_address          -> arbiter
//     req_read_ready / req_read_data             <- arbiter
//     req_write_valid / req_write_address /
//     req_write_data                             -> arbiter
//     req_write_ready                            <- arbiter
//   Memory side:
//     mem_read_valid / mem_read_address          <- arbiter
//     mem_read_ready / mem_read_data             -> arbiter
//     mem_write_valid / mem_write_address /
//     mem_write_data                             <- arbiter
//     mem_write_ready                            -> arbiter
//
//   modport master : the arbiter itself
//   modport slave  : the surrounding environment (LSUs + memory)
interface mem_port_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]                req_read_valid;
  logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_read_address;
  logic [NUM_REQ-1:0]                req_read_ready;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] req_read_data;
  logic [NUM_REQ-1:0]                req_write_valid;
  logic [NUM_REQ-1:0][ADDR_BITS-1:0] req_write_address;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] req_write_data;
  logic [NUM_REQ-1:0]                req_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  req_read_valid, req_read_address,
    output req_read_ready, req_read_data,
    input  req_write_valid, req_write_address, req_write_data,
    output req_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output req_read_valid, req_read_address,
    input  req_read_ready, req_read_data,
    output req_write_valid, req_write_address, req_write_data,
    input  req_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter sharing one external data-memory port among NUM_REQ
//   LSU channels. One transaction (read or write) in flight at a time, with
//   valid/ready four-phase handshakes on both sides and a stall watchdog
//   that raises a sticky error and completes the stuck transaction.
//
//   Ports:
//     clk    in   clock
//     reset  in   asynchronous, active-low reset
//     bus    --   mem_port_arbiter_if.master (requester + memory handshakes)
//     busy   out  high whenever the FSM is not idle
//     error  out  sticky watchdog timeout flag, cleared only by reset
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   IDLE        | scanning requesters from rr pointer, no transaction active
//   READ_WAIT   | mem_read_valid high, waiting for mem_read_ready or timeout
//   WRITE_WAIT  | mem_write_valid high, waiting for mem_write_ready or timeout
//   RELEASE     | requester ready high, waiting for its valid to drop
module mem_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic               error
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // A disabled watchdog still needs a legal 1-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_WRITE_WAIT,
    ST_RELEASE
  } state_t;

  state_t                            state_q, state_d;
  logic [PTR_W-1:0]                  rr_q, rr_d;
  logic [PTR_W-1:0]                  id_q, id_d;
  logic                              is_read_q, is_read_d;
  logic [ADDR_BITS-1:0]              addr_q, addr_d;
  logic [DATA_BITS-1:0]              wdata_q, wdata_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              err_q, err_d;
  logic [NUM_REQ-1:0]                rd_rdy_q, rd_rdy_d;
  logic [NUM_REQ-1:0]                wr_rdy_q, wr_rdy_d;
  logic [NUM_REQ-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                              mrv_q, mrv_d;
  logic                              mwv_q, mwv_d;

  logic                              scan_found;
  logic                              scan_rd;
  logic [PTR_W-1:0]                  scan_idx;
  logic [PTR_W-1:0]                  scan_cand;
  logic [CNT_W-1:0]                  cnt_inc;
  logic                              tmo_hit;

  // base + off modulo NUM_REQ; both operands are already < NUM_REQ, so one
  // conditional subtract is enough and non-power-of-2 NUM_REQ wraps correctly.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[PTR_W-1:0];
  endfunction

  // Round-robin scan; a requester with both valids is granted its read first.
  always_comb begin
    scan_found = 1'b0;
    scan_rd    = 1'b0;
    scan_idx   = '0;
    scan_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_cand = wrap_add(rr_q, i);
      if (!scan_found &&
          (bus.req_read_valid[scan_cand] || bus.req_write_valid[scan_cand])) begin
        scan_found = 1'b1;
        scan_idx   = scan_cand;
        scan_rd    = bus.req_read_valid[scan_cand];
      end
    end
  end

  // The counter holds the number of wait edges seen; it fires on the edge
  // where it would reach TIMEOUT_CYCLES. A memory ready on that same edge wins.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign tmo_hit = TMO_EN && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_rdy_d  = rd_rdy_q;
    wr_rdy_d  = wr_rdy_q;
    rd_data_d = rd_data_q;
    mrv_d     = mrv_q;
    mwv_d     = mwv_q;

    case (state_q)
      ST_IDLE: begin
        if (scan_found) begin
          id_d      = scan_idx;
          is_read_d = scan_rd;
          cnt_d     = '0;
          if (scan_rd) begin
            addr_d  = bus.req_read_address[scan_idx];
            mrv_d   = 1'b1;
            state_d = ST_READ_WAIT;
          end else begin
            addr_d  = bus.req_write_address[scan_idx];
            wdata_d = bus.req_write_data[scan_idx];
            mwv_d   = 1'b1;
            state_d = ST_WRITE_WAIT;
          end
        end
      end

      ST_READ_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.mem_read_ready) begin
          mrv_d           = 1'b0;
          rd_data_d[id_q] = bus.mem_read_data;
          rd_rdy_d[id_q]  = 1'b1;
          state_d         = ST_RELEASE;
        end else if (tmo_hit) begin
          err_d           = 1'b1;
          mrv_d           = 1'b0;
          rd_data_d[id_q] = '0;
          rd_rdy_d[id_q]  = 1'b1;
          state_d         = ST_RELEASE;
        end
      end

      ST_WRITE_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.mem_write_ready) begin
          mwv_d          = 1'b0;
          wr_rdy_d[id_q] = 1'b1;
          state_d        = ST_RELEASE;
        end else if (tmo_hit) begin
          err_d          = 1'b1;
          mwv_d          = 1'b0;
          wr_rdy_d[id_q] = 1'b1;
          state_d        = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (is_read_q ? !bus.req_read_valid[id_q] : !bus.req_write_valid[id_q]) begin
          rd_rdy_d = '0;
          wr_rdy_d = '0;
          rr_d     = wrap_add(id_q, 1);
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
      rd_data_q <= '0;
      mrv_q     <= 1'b0;
      mwv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
      rd_data_q <= rd_data_d;
      mrv_q     <= mrv_d;
      mwv_q     <= mwv_d;
    end
  end

  // Read and write share one address register; only the matching valid is high.
  assign bus.req_read_ready    = rd_rdy_q;
  assign bus.req_read_data     = rd_data_q;
  assign bus.req_write_ready   = wr_rdy_q;
  assign bus.mem_read_valid    = mrv_q;
  assign bus.mem_read_address  = addr_q;
  assign bus.mem_write_valid   = mwv_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = wdata_q;
  assign busy                  = (state_q != ST_IDLE);
  assign error                 = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (NUM_REQ=4, 8-bit address/data,
//   TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on the falling
//   clock edge; the design acts on the rising edge.
module tb_mem_port_arbiter;
  localparam int NR  = 4;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic error;
  int   tests = 0;
  int   fails = 0;

  mem_port_arbiter_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .error (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   busy, 64'd0);
    check({tag, "_error"},  error, 64'd0);
    check({tag, "_rrdy"},   bus.req_read_ready, 64'd0);
    check({tag, "_wrdy"},   bus.req_write_ready, 64'd0);
    check({tag, "_rdata"},  bus.req_read_data, 64'd0);
    check({tag, "_mrv"},    bus.mem_read_valid, 64'd0);
    check({tag, "_mwv"},    bus.mem_write_valid, 64'd0);
    check({tag, "_maddr"},  bus.mem_read_address, 64'd0);
    check({tag, "_mwaddr"}, bus.mem_write_address, 64'd0);
    check({tag, "_mwdata"}, bus.mem_write_data, 64'd0);
  endtask

  // Waits (bounded) for a read grant, checks it, returns data with 1-cycle
  // memory latency and completes the requester handshake.
  task automatic serve_read(input string tag, input int id,
                            input logic [AB-1:0] addr, input logic [DB-1:0] data);
    int waited = 0;
    while (bus.mem_read_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, "_grant"}, bus.mem_read_valid, 64'd1);
    check({tag, "_addr"},  bus.mem_read_address, 64'(addr));
    check({tag, "_nowr"},  bus.mem_write_valid, 64'd0);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = data;
    tick();
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    check({tag, "_rdy"},  bus.req_read_ready, 64'(NR'(1) << id));
    check({tag, "_data"}, bus.req_read_data[id], 64'(data));
    bus.req_read_valid[id] = 1'b0;
    tick();
  endtask

  task automatic serve_write(input string tag, input int id,
                             input logic [AB-1:0] addr, input logic [DB-1:0] data);
    int waited = 0;
    while (bus.mem_write_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, "_grant"}, bus.mem_write_valid, 64'd1);
    check({tag, "_addr"},  bus.mem_write_address, 64'(addr));
    check({tag, "_wdata"}, bus.mem_write_data, 64'(data));
    check({tag, "_nord"},  bus.mem_read_valid, 64'd0);
    bus.mem_write_ready = 1'b1;
    tick();
    bus.mem_write_ready = 1'b0;
    check({tag, "_rdy"}, bus.req_write_ready, 64'(NR'(1) << id));
    bus.req_write_valid[id] = 1'b0;
    tick();
  endtask

  initial begin
    reset                 = 1'b0;
    bus.req_read_valid    = '0;
    bus.req_read_address  = '0;
    bus.req_write_valid   = '0;
    bus.req_write_address = '0;
    bus.req_write_data    = '0;
    bus.mem_read_ready    = 1'b0;
    bus.mem_read_data     = '0;
    bus.mem_write_ready   = 1'b0;

    // Reset state
    tick(2);
    check_zero("rst");
    reset = 1'b1;
    tick();

    // Round robin from pointer 0: all four read together -> 0,1,2,3
    for (int i = 0; i < NR; i++) begin
      bus.req_read_valid[i]   = 1'b1;
      bus.req_read_address[i] = AB'(8'h40 + i);
    end
    for (int i = 0; i < NR; i++)
      serve_read($sformatf("rr%0d", i), i, AB'(8'h40 + i), DB'(8'hC0 + i));

    // Pointer wrapped to 0 after 3: req0 before req2
    bus.req_read_valid[0]   = 1'b1;
    bus.req_read_address[0] = 8'h50;
    bus.req_read_valid[2]   = 1'b1;
    bus.req_read_address[2] = 8'h52;
    serve_read("rrb0", 0, 8'h50, 8'hD0);
    serve_read("rrb2", 2, 8'h52, 8'hD2);

    // Single read, 3-cycle memory (pointer=3, scan 3,0 -> req0)
    bus.req_read_valid[0]   = 1'b1;
    bus.req_read_address[0] = 8'h10;
    tick();
    check("t1_mrv",  bus.mem_read_valid, 64'd1);
    check("t1_addr", bus.mem_read_address, 64'h10);
    check("t1_busy", busy, 64'd1);
    tick(2);
    check("t1_hold", bus.mem_read_valid, 64'd1);
    check("t1_nrdy", bus.req_read_ready, 64'd0);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'hAB;
    tick();
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    check("t1_rdy",  bus.req_read_ready, 64'b0001);
    check("t1_data", bus.req_read_data[0], 64'hAB);
    check("t1_mrv0", bus.mem_read_valid, 64'd0);
    tick();
    check("t1_rdyhold",  bus.req_read_ready, 64'b0001);
    check("t1_busyhold", busy, 64'd1);
    bus.req_read_valid[0] = 1'b0;
    tick();
    check("t1_idle",  busy, 64'd0);
    check("t1_rdy0",  bus.req_read_ready, 64'd0);
    check("t1_dkeep", bus.req_read_data[0], 64'hAB);

    // Read/write priority (pointer=1): req1 read first, then req3 write is
    // ahead of req1's write in the next pass (pointer=2)
    bus.req_read_valid[1]    = 1'b1;
    bus.req_read_address[1]  = 8'h20;
    bus.req_write_valid[1]   = 1'b1;
    bus.req_write_address[1] = 8'h21;
    bus.req_write_data[1]    = 8'h55;
    serve_read("pri_r1", 1, 8'h20, 8'h9E);
    bus.req_write_valid[3]   = 1'b1;
    bus.req_write_address[3] = 8'h33;
    bus.req_write_data[3]    = 8'h77;
    serve_write("pri_w3", 3, 8'h33, 8'h77);
    serve_write("pri_w1", 1, 8'h21, 8'h55);

    // Write timeout (pointer=2): memory never readies
    bus.req_write_valid[2]   = 1'b1;
    bus.req_write_address[2] = 8'h99;
    bus.req_write_data[2]    = 8'h11;
    tick();
    check("to_mwv",  bus.mem_write_valid, 64'd1);
    check("to_addr", bus.mem_write_address, 64'h99);
    check("to_err0", error, 64'd0);
    tick(7);
    check("to_hold7", bus.mem_write_valid, 64'd1);
    check("to_err7",  error, 64'd0);
    check("to_nrdy7", bus.req_write_ready, 64'd0);
    tick();
    check("to_err",  error, 64'd1);
    check("to_mwv0", bus.mem_write_valid, 64'd0);
    check("to_rdy",  bus.req_write_ready, 64'b0100);
    bus.req_write_valid[2] = 1'b0;
    tick();
    check("to_idle", busy, 64'd0);
    check("to_errk", error, 64'd1);

    // Later successful read keeps error set (pointer=3, scan 3,0 -> req0)
    bus.req_read_valid[0]   = 1'b1;
    bus.req_read_address[0] = 8'h0F;
    serve_read("post", 0, 8'h0F, 8'h5A);
    check("post_err", error, 64'd1);

    // Reset in the middle of READ_WAIT (pointer=1 -> req1 granted)
    bus.req_read_valid[1]   = 1'b1;
    bus.req_read_address[1] = 8'h71;
    tick();
    check("ar_mrv",  bus.mem_read_valid, 64'd1);
    check("ar_addr", bus.mem_read_address, 64'h71);
    bus.req_read_valid[0]   = 1'b1;
    bus.req_read_address[0] = 8'h60;
    bus.req_read_valid[2]   = 1'b1;
    bus.req_read_address[2] = 8'h72;
    #2 reset = 1'b0;
    #1 check_zero("ar");
    bus.req_read_valid[1] = 1'b0;
    tick();
    reset = 1'b1;
    // Pointer back at 0: pending req0 goes before req2
    serve_read("ar0", 0, 8'h60, 8'h16);
    serve_read("ar2", 2, 8'h72, 8'h27);

    // Ready on the same edge as the timeout would fire (pointer=3)
    bus.req_read_valid[3]   = 1'b1;
    bus.req_read_address[3] = 8'h3D;
    tick();
    check("co_mrv", bus.mem_read_valid, 64'd1);
    tick(7);
    check("co_hold", bus.mem_read_valid, 64'd1);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'hC3;
    tick();
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    check("co_err",  error, 64'd0);
    check("co_rdy",  bus.req_read_ready, 64'b1000);
    check("co_data", bus.req_read_data[3], 64'hC3);
    bus.req_read_valid[3] = 1'b0;
    tick();
    check("co_idle", busy, 64'd0);
    check("co_err2", error, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
